// File: rtl/shadow_register_restorer.sv
// rtl/shadow_register_restorer.sv - mret frame restore: reload saved registers from the stack and pop the frame (optional mepc/mcause reload under SHADOW_RESTORE_CSR_EN)
module shadow_register_restorer #(
  parameter int DATA_WIDTH       = 64,
  parameter int ADDR_WIDTH       = 5,
  parameter int MAX_OUTSTANDING  = 2,
  parameter int NUM_SHADOW_SAVES = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  restore_req_i,
  input  logic                                  flush_i,
  input  logic [DATA_WIDTH-1:0]                 frame_base_i,
  input  logic [$clog2(NUM_SHADOW_SAVES+1)-1:0] save_level_i,
  output logic                                  ld_valid_o,
  input  logic                                  ld_ready_i,
  output logic [DATA_WIDTH-1:0]                 ld_addr_o,
  input  logic                                  ld_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]                 ld_rsp_data_i,
  output logic                                  rf_we_o,
  output logic [ADDR_WIDTH-1:0]                 rf_waddr_o,
  output logic [DATA_WIDTH-1:0]                 rf_wdata_o,
  output logic                                  csr_we_o,
  output logic                                  csr_sel_o,
  output logic [DATA_WIDTH-1:0]                 csr_wdata_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  level_dec_o,
  output logic                                  err_o
);

`ifdef SHADOW_RESTORE_CSR_EN
  localparam int FRAME_WORDS   = 33;
  localparam int NUM_REG_LOADS = 30;
`else
  localparam int FRAME_WORDS   = 31;
`endif
  // Every frame word except the reserved x2 slot is loaded.
  localparam int NUM_LOADS  = FRAME_WORDS - 1;
  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int CNT_W      = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [5:0]            LAST_IDX    = 6'(NUM_LOADS - 1);
  localparam logic [CNT_W-1:0]      MAX_CNT     = CNT_W'(MAX_OUTSTANDING);
  localparam logic [DATA_WIDTH-1:0] FRAME_BYTES = DATA_WIDTH'(FRAME_WORDS * (DATA_WIDTH / 8));

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE_SP, S_DONE, S_FLUSH} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_base;
  logic [CNT_W-1:0]      r_outstanding;
  logic [5:0]            r_issue_idx;
  logic [5:0]            r_rsp_idx;
  logic                  r_rsp_we;
  logic [ADDR_WIDTH-1:0] r_rsp_waddr;
  logic [DATA_WIDTH-1:0] r_rsp_wdata;
  logic                  r_err;
  logic                  w_start;
  logic                  w_accept;
  logic                  w_rsp;
  logic                  w_rsp_keep;
  logic [5:0]            w_issue_word;

  // Load index n maps to frame word n, skipping word 1 (the x2 slot).
  assign w_issue_word = (r_issue_idx == 6'd0) ? 6'd0 : r_issue_idx + 6'd1;
  assign ld_addr_o    = r_base + (DATA_WIDTH'(w_issue_word) << BYTE_SHIFT);
  assign w_start      = (r_state == S_IDLE) && restore_req_i && (save_level_i != '0);
  assign w_accept     = ld_valid_o && ld_ready_i;
  // Responses only count against a live load; stray ones in IDLE or with nothing pending are dropped.
  assign w_rsp        = ld_rsp_valid_i && (r_state != S_IDLE) && (r_outstanding != '0);
  assign w_rsp_keep   = w_rsp && (r_state != S_FLUSH) && !flush_i;
  assign err_o        = r_err;

`ifdef SHADOW_RESTORE_CSR_EN
  logic r_csr_we;
  logic r_csr_sel;
  assign csr_we_o    = r_csr_we;
  assign csr_sel_o   = r_csr_sel;
  assign csr_wdata_o = r_rsp_wdata;
`else
  assign csr_we_o    = 1'b0;
  assign csr_sel_o   = 1'b0;
  assign csr_wdata_o = '0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next state, load issue and the rf write mux (sp pop overrides the response path).
  always_comb begin
    w_next_state = r_state;
    ld_valid_o   = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    level_dec_o  = 1'b0;
    rf_we_o      = r_rsp_we;
    rf_waddr_o   = r_rsp_waddr;
    rf_wdata_o   = r_rsp_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        busy_o = 1'b1;
        if (flush_i) begin
          w_next_state = S_FLUSH;
        end else begin
          ld_valid_o = (r_outstanding < MAX_CNT);
          if (ld_valid_o && ld_ready_i && (r_issue_idx == LAST_IDX)) w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy_o = 1'b1;
        if (flush_i)                    w_next_state = S_FLUSH;
        else if (r_outstanding == '0)   w_next_state = S_WRITE_SP;
      end
      S_WRITE_SP: begin
        busy_o = 1'b1;
        if (flush_i) begin
          w_next_state = S_IDLE;
        end else begin
          rf_we_o      = 1'b1;
          rf_waddr_o   = ADDR_WIDTH'(2);
          rf_wdata_o   = r_base + FRAME_BYTES;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        done_o       = 1'b1;
        level_dec_o  = 1'b1;
        w_next_state = S_IDLE;
      end
      S_FLUSH: begin
        busy_o = 1'b1;
        if (r_outstanding == '0) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Frame base, issue/response indices, outstanding-load counter and the error pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_base        <= '0;
      r_issue_idx   <= '0;
      r_rsp_idx     <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_start) begin
        r_base      <= frame_base_i;
        r_issue_idx <= '0;
      end else if (w_accept) begin
        r_issue_idx <= r_issue_idx + 6'd1;
      end
      if (w_start)         r_rsp_idx <= '0;
      else if (w_rsp_keep) r_rsp_idx <= r_rsp_idx + 6'd1;
      if (w_accept && !w_rsp)      r_outstanding <= r_outstanding + CNT_W'(1);
      else if (!w_accept && w_rsp) r_outstanding <= r_outstanding - CNT_W'(1);
      r_err <= (r_state == S_IDLE) && restore_req_i && (save_level_i == '0);
    end
  end

  // Registered response write-back, one cycle after the load data arrives.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rsp_we    <= 1'b0;
      r_rsp_waddr <= '0;
      r_rsp_wdata <= '0;
`ifdef SHADOW_RESTORE_CSR_EN
      r_csr_we    <= 1'b0;
      r_csr_sel   <= 1'b0;
`endif
    end else begin
      r_rsp_we <= 1'b0;
`ifdef SHADOW_RESTORE_CSR_EN
      r_csr_we <= 1'b0;
      if (w_rsp_keep) begin
        r_rsp_wdata <= ld_rsp_data_i;
        if (r_rsp_idx >= 6'(NUM_REG_LOADS)) begin
          r_csr_we  <= 1'b1;
          r_csr_sel <= (r_rsp_idx != 6'(NUM_REG_LOADS));
        end else begin
          r_rsp_we    <= 1'b1;
          r_rsp_waddr <= ADDR_WIDTH'((r_rsp_idx == 6'd0) ? 6'd1 : r_rsp_idx + 6'd2);
        end
      end
`else
      if (w_rsp_keep) begin
        r_rsp_wdata <= ld_rsp_data_i;
        r_rsp_we    <= 1'b1;
        r_rsp_waddr <= ADDR_WIDTH'((r_rsp_idx == 6'd0) ? 6'd1 : r_rsp_idx + 6'd2);
      end
`endif
    end
  end

endmodule
